// File: rtl/rs_dispatch_arbiter_pkg.sv
// Shared types and sizing for the RS dispatch arbiter slice.
package rs_dispatch_arbiter_pkg;

   localparam int MACHINE_WIDTH    = 4;
   localparam int ISSUE_WIDTH      = 4;
   localparam int NUM_RS_BANKS     = 2;
   localparam int RS_DEPTH_DEFAULT = 16;
   localparam int RS_CREDIT_W      = $clog2(RS_DEPTH_DEFAULT) + 1;
   localparam int FREE_W_DEFAULT   = $clog2(ISSUE_WIDTH + 1);

   typedef struct packed {
      logic       packet_valid;
      logic [5:0] rob_idx;
      logic [7:0] opcode;
   } dispatch_rs_packet_t;

   typedef dispatch_rs_packet_t [MACHINE_WIDTH-1:0] dispatch_group_t;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_HOLD  = 1'b1
   } arb_state_t;

   // Per-slot valid bits of a dispatch group.
   function automatic logic [MACHINE_WIDTH-1:0] group_mask(input dispatch_group_t grp);
      logic [MACHINE_WIDTH-1:0] m;
      for (int s = 0; s < MACHINE_WIDTH; s++) m[s] = grp[s].packet_valid;
      return m;
   endfunction

endpackage

// File: rtl/rs_dispatch_arbiter_steer.sv
// dispatch_steer: combinational slot-to-bank assignment with per-bank compaction.
// Slots are walked in program order; the first slot that finds no bank with
// effective credit stops the walk so later slots never overtake it.
// Macro RS_STEER_BALANCE_EN selects largest-effective-credit steering
// (ties to the lowest bank); otherwise slots fill the lowest bank with credit.
module dispatch_steer
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter int NUM_BANKS = NUM_RS_BANKS,
   parameter int CREDIT_W  = RS_CREDIT_W
)(
   input  logic                                                  enable,
   input  dispatch_group_t                                       hold_pkt,
   input  logic [MACHINE_WIDTH-1:0]                              rem_mask,
   input  logic [NUM_BANKS-1:0][CREDIT_W-1:0]                    credit,
   output dispatch_rs_packet_t [NUM_BANKS-1:0][MACHINE_WIDTH-1:0] bank_pkt,
   output logic [MACHINE_WIDTH-1:0]                              sent_mask,
   output logic [NUM_BANKS-1:0][CREDIT_W-1:0]                    sent_cnt
);

   logic [NUM_BANKS-1:0][CREDIT_W-1:0] eff;
   logic [NUM_BANKS-1:0]               pick;
   logic                               found;
   logic                               stalled;
`ifdef RS_STEER_BALANCE_EN
   logic [CREDIT_W-1:0]                best;
`endif

   // In-order walk: pick a bank per slot, place it at the bank's next compacted position.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      eff       = credit;
      bank_pkt  = '0;
      sent_mask = '0;
      sent_cnt  = '0;
      pick      = '0;
      found     = 1'b0;
      stalled   = 1'b0;
`ifdef RS_STEER_BALANCE_EN
      best      = '0;
`endif
      for (int s = 0; s < MACHINE_WIDTH; s++) begin
         if (enable && rem_mask[s] && !stalled) begin
            found = 1'b0;
            pick  = '0;
`ifdef RS_STEER_BALANCE_EN
            best  = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (eff[b] != '0 && (!found || eff[b] > best)) begin
                  found   = 1'b1;
                  best    = eff[b];
                  pick    = '0;
                  pick[b] = 1'b1;
               end
            end
`else
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (eff[b] != '0 && !found) begin
                  found   = 1'b1;
                  pick[b] = 1'b1;
               end
            end
`endif
            if (found) begin
               sent_mask[s] = 1'b1;
               for (int b = 0; b < NUM_BANKS; b++) begin
                  if (pick[b]) begin
                     for (int k = 0; k < MACHINE_WIDTH; k++) begin
                        if (CREDIT_W'(k) == sent_cnt[b]) bank_pkt[b][k] = hold_pkt[s];
                     end
                     sent_cnt[b] = sent_cnt[b] + CREDIT_W'(1);
                     eff[b]      = eff[b] - CREDIT_W'(1);
                  end
               end
            end else begin
               stalled = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// rs_dispatch_arbiter: holds one renamed dispatch group and streams its slots
// in program order onto the RS banks, tracking free entries with credits.
// Optional macro RS_STEER_BALANCE_EN switches steering to credit balancing.
module rs_dispatch_arbiter
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter  int NUM_BANKS = NUM_RS_BANKS,
   parameter  int RS_DEPTH  = RS_DEPTH_DEFAULT,
   parameter  int FREE_W    = FREE_W_DEFAULT,
   localparam int CREDIT_W  = $clog2(RS_DEPTH) + 1
)(
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  pipe_flush,
   input  dispatch_group_t                                       in_pkt,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   output dispatch_rs_packet_t [NUM_BANKS-1:0][MACHINE_WIDTH-1:0] bank_pkt,
   input  logic [NUM_BANKS-1:0][FREE_W-1:0]                      bank_freed,
   output logic [NUM_BANKS-1:0][CREDIT_W-1:0]                    bank_credit,
   output logic                                                  hold_busy
);

   arb_state_t                         state, state_nxt;
   dispatch_group_t                    hold_pkt;
   logic [MACHINE_WIDTH-1:0]           rem_mask, mask_nxt, sent_mask;
   logic [NUM_BANKS-1:0][CREDIT_W-1:0] credit, credit_nxt, sent_cnt;
   logic [NUM_BANKS-1:0][CREDIT_W:0]   credit_sum;
   logic                               load, all_sent;

   dispatch_steer #(
      .NUM_BANKS (NUM_BANKS),
      .CREDIT_W  (CREDIT_W)
   ) u_steer (
      .enable    ((state == ARB_HOLD) && !pipe_flush),
      .hold_pkt  (hold_pkt),
      .rem_mask  (rem_mask),
      .credit    (credit),
      .bank_pkt  (bank_pkt),
      .sent_mask (sent_mask),
      .sent_cnt  (sent_cnt)
   );

   assign all_sent    = ((rem_mask & ~sent_mask) == '0);
   assign bank_credit = credit;
   assign hold_busy   = (state == ARB_HOLD);

   // FSM next state, hold-mask update and acceptance handshake.
   always_comb begin
      state_nxt = state;
      mask_nxt  = rem_mask & ~sent_mask;
      load      = 1'b0;
      in_ready  = 1'b0;
      case (state)
         ARB_EMPTY: in_ready = 1'b1;
         ARB_HOLD: begin
            in_ready = all_sent;
            if (all_sent) state_nxt = ARB_EMPTY;
         end
         default: state_nxt = ARB_EMPTY;
      endcase
      if (pipe_flush) in_ready = 1'b0;
      if (in_valid && in_ready) begin
         load      = 1'b1;
         mask_nxt  = group_mask(in_pkt);
         // An all-invalid group is consumed without ever occupying HOLD.
         state_nxt = (group_mask(in_pkt) != '0) ? ARB_HOLD : ARB_EMPTY;
      end
      if (pipe_flush) begin
         state_nxt = ARB_EMPTY;
         mask_nxt  = '0;
      end
   end

   // Credit update: sent and freed both apply; flush restores full credit.
   always_comb begin
      credit_sum = '0;
      credit_nxt = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         credit_sum[b] = {1'b0, credit[b]} + (CREDIT_W+1)'(bank_freed[b]) - {1'b0, sent_cnt[b]};
         credit_nxt[b] = pipe_flush ? CREDIT_W'(RS_DEPTH) : credit_sum[b][CREDIT_W-1:0];
      end
   end

   // Control state register: FSM state, remaining-slot mask and bank credits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state    <= ARB_EMPTY;
         rem_mask <= '0;
         credit   <= {NUM_BANKS{CREDIT_W'(RS_DEPTH)}};
      end else begin
         state    <= state_nxt;
         rem_mask <= mask_nxt;
         credit   <= credit_nxt;
      end
   end

   // Group payload register, loaded on accept.
   always_ff @(posedge clk) begin
      // NOTE: payload needs no reset; rem_mask alone decides which slots are live.
      if (load) hold_pkt <= in_pkt;
   end

   // Credits must stay within [0, RS_DEPTH]; an underflow wraps high and is caught too.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_credit_chk
      credit_bound_a : assert property (@(posedge clk) disable iff (!rst_n || pipe_flush)
         credit_sum[b] <= (CREDIT_W+1)'(RS_DEPTH));
   end

endmodule
